// File: rtl/burst_ram_responder.sv
// Burst RAM responder: memory-array model of the external burst RAM behind the br_ command
// interface. It accepts single-cycle read/write burst commands, moves BURST_DATA_COUNT
// consecutive beats per burst and holds br_busy high during bursts and during a post-reset
// init period.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   br_cmd            0 = read, 1 = write
//   br_cmd_en         command strobe, honoured only while br_busy = 0
//   br_addr           beat address of the first beat (latched at acceptance)
//   br_wr_data        write beat data (beat 0 arrives together with the command)
//   br_data_mask      per-byte write mask, 1 = byte left unchanged
//   br_rd_data        read beat data, zero whenever br_rd_data_valid = 0
//   br_rd_data_valid  br_rd_data carries a read beat
//   br_busy           a command presented this cycle is dropped
module burst_ram_responder #(
  parameter int unsigned DEPTH_BITWIDTH   = 8,
  parameter int unsigned DATA_BITWIDTH    = 64,
  parameter int unsigned BURST_DATA_COUNT = 4,
  parameter int unsigned READ_LATENCY     = 2,
  parameter int unsigned INIT_CYCLES      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       br_cmd,
  input  logic                       br_cmd_en,
  input  logic [DEPTH_BITWIDTH-1:0]  br_addr,
  input  logic [DATA_BITWIDTH-1:0]   br_wr_data,
  input  logic [DATA_BITWIDTH/8-1:0] br_data_mask,
  output logic [DATA_BITWIDTH-1:0]   br_rd_data,
  output logic                       br_rd_data_valid,
  output logic                       br_busy
);

  localparam int unsigned MaskW  = DATA_BITWIDTH / 8;
  localparam int unsigned Depth  = 2 ** DEPTH_BITWIDTH;
  localparam int unsigned CntMax =
      (INIT_CYCLES > READ_LATENCY) ?
      ((INIT_CYCLES > BURST_DATA_COUNT) ? INIT_CYCLES : BURST_DATA_COUNT) :
      ((READ_LATENCY > BURST_DATA_COUNT) ? READ_LATENCY : BURST_DATA_COUNT);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] InitLast  = CntW'(INIT_CYCLES - 1);
  localparam logic [CntW-1:0] LatLast   = CntW'((READ_LATENCY == 0) ? 0 : READ_LATENCY - 1);
  localparam logic [CntW-1:0] BurstLast = CntW'(BURST_DATA_COUNT - 1);
  localparam logic [CntW-1:0] BurstCnt  = CntW'(BURST_DATA_COUNT);

  typedef enum logic [2:0] {StInit, StIdle, StWrite, StReadWait, StRead} state_e;

  logic [DATA_BITWIDTH-1:0] mem [Depth];

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [DEPTH_BITWIDTH-1:0] addr_q, addr_d;
  logic                      busy_q, busy_d;
  logic                      valid_q;
  logic [DATA_BITWIDTH-1:0]  rd_data_q;

  logic                      wr_en, rd_en;
  logic [DEPTH_BITWIDTH-1:0] wr_addr, rd_addr;

  // cnt_q meaning per state: StInit cycles elapsed, StWrite beats written,
  // StReadWait latency cycles elapsed, StRead beats already issued to the output register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    wr_en   = 1'b0;
    wr_addr = addr_q;
    rd_en   = 1'b0;
    rd_addr = addr_q;

    unique case (state_q)
      StInit: begin
        busy_d = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == InitLast) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end

      StIdle: begin
        busy_d = 1'b0;
        if (br_cmd_en && !busy_q) begin
          if (br_cmd) begin
            // Beat 0 travels with the command and is written on acceptance.
            wr_en   = 1'b1;
            wr_addr = br_addr;
            addr_d  = br_addr + 1'b1;
            cnt_d   = CntW'(1);
            if (BURST_DATA_COUNT > 1) begin
              state_d = StWrite;
              busy_d  = 1'b1;
            end
          end else begin
            busy_d = 1'b1;
            if (READ_LATENCY == 0) begin
              rd_en   = 1'b1;
              rd_addr = br_addr;
              addr_d  = br_addr + 1'b1;
              cnt_d   = CntW'(1);
              state_d = StRead;
            end else begin
              addr_d  = br_addr;
              cnt_d   = '0;
              state_d = StReadWait;
            end
          end
        end
      end

      StWrite: begin
        wr_en  = 1'b1;
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == BurstLast) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end

      StReadWait: begin
        cnt_d = cnt_q + 1'b1;
        // Fetch beat 0 in the last wait cycle so it is registered on the first read cycle.
        if (cnt_q == LatLast) begin
          rd_en   = 1'b1;
          addr_d  = addr_q + 1'b1;
          cnt_d   = CntW'(1);
          state_d = StRead;
        end
      end

      StRead: begin
        if (cnt_q == BurstCnt) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          rd_en  = 1'b1;
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StInit;
        busy_d  = 1'b1;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
      cnt_q   <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      valid_q <= rd_en;
    end
  end

  // A reset aborts any burst in flight, so the beat presented in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      for (int unsigned j = 0; j < MaskW; j++) begin
        if (!br_data_mask[j]) begin
          mem[wr_addr][8*j +: 8] <= br_wr_data[8*j +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign br_rd_data       = rd_data_q;
  assign br_rd_data_valid = valid_q;
  assign br_busy          = busy_q;

endmodule

// File: tb/tb_burst_ram_responder.sv
// Self-checking bench for burst_ram_responder (default parameters). A directed vector table
// covers reset and a first write/read, hand-written sequences cover masking, wrap, dropped
// strobes and reset during a read, then random traffic runs against a cycle-schedule model.
module tb_burst_ram_responder;

  localparam int Burst = 4;
  localparam int Lat   = 2;
  localparam int Init  = 8;

  logic        clk;
  logic        rst;
  logic        br_cmd;
  logic        br_cmd_en;
  logic [7:0]  br_addr;
  logic [63:0] br_wr_data;
  logic [7:0]  br_data_mask;
  logic [63:0] br_rd_data;
  logic        br_rd_data_valid;
  logic        br_busy;

  burst_ram_responder dut (
    .clk              (clk),
    .rst              (rst),
    .br_cmd           (br_cmd),
    .br_cmd_en        (br_cmd_en),
    .br_addr          (br_addr),
    .br_wr_data       (br_wr_data),
    .br_data_mask     (br_data_mask),
    .br_rd_data       (br_rd_data),
    .br_rd_data_valid (br_rd_data_valid),
    .br_busy          (br_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: memory image, first cycle the responder is free again, the pending
  // write burst, and the read beats expected on future cycles keyed by cycle number.
  logic [63:0] ref_mem [256];
  logic [63:0] exp_rd [int];
  logic [63:0] rd_log [$];
  int          cyc     = 0;
  int          free_at = 0;
  int          wr_left = 0;
  logic [7:0]  m_addr  = '0;
  logic        armed   = 1'b0;

  typedef struct {
    logic        chk;
    logic        r;
    logic        en;
    logic        cmd;
    logic [7:0]  addr;
    logic [63:0] wd;
    logic [7:0]  mask;
    logic        busy;
    logic        valid;
    logic [63:0] rd;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(input logic chk, input logic r, input logic en, input logic cmd,
                              input logic [7:0] addr, input logic [63:0] wd,
                              input logic [7:0] mask, input logic busy, input logic valid,
                              input logic [63:0] rd);
    vec_t v;
    v.chk = chk; v.r = r; v.en = en; v.cmd = cmd; v.addr = addr; v.wd = wd;
    v.mask = mask; v.busy = busy; v.valid = valid; v.rd = rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_write(input logic [7:0] a, input logic [63:0] d, input logic [7:0] m);
    for (int j = 0; j < 8; j++) begin
      if (!m[j]) ref_mem[a][8*j +: 8] = d[8*j +: 8];
    end
  endtask

  // One clock cycle: apply inputs, compare outputs with the model, advance the model.
  task automatic drive(input logic r, input logic en, input logic cmd, input logic [7:0] a,
                       input logic [63:0] wd, input logic [7:0] m);
    logic        e_valid;
    logic [63:0] e_data;
    rst = r; br_cmd_en = en; br_cmd = cmd; br_addr = a; br_wr_data = wd; br_data_mask = m;
    if (armed) begin
      e_valid = exp_rd.exists(cyc);
      e_data  = e_valid ? exp_rd[cyc] : 64'h0;
      check("model_busy", 64'(br_busy), 64'(cyc < free_at));
      check("model_valid", 64'(br_rd_data_valid), 64'(e_valid));
      check("model_data", br_rd_data, e_data);
    end
    if (exp_rd.exists(cyc)) exp_rd.delete(cyc);
    if (br_rd_data_valid === 1'b1) rd_log.push_back(br_rd_data);

    if (r) begin
      free_at = cyc + 1 + Init;
      wr_left = 0;
      exp_rd.delete();
      armed   = 1'b1;
    end else if (wr_left > 0) begin
      model_write(m_addr, wd, m);
      m_addr  = m_addr + 8'd1;
      wr_left = wr_left - 1;
    end else if (en && cyc >= free_at) begin
      if (cmd) begin
        model_write(a, wd, m);
        m_addr  = a + 8'd1;
        wr_left = Burst - 1;
        free_at = cyc + Burst;
      end else begin
        for (int i = 0; i < Burst; i++) exp_rd[cyc + 1 + Lat + i] = ref_mem[8'(a + i)];
        free_at = cyc + Lat + Burst + 1;
      end
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (cyc < free_at && k < 64) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 8'hFF);
      k++;
    end
    if (cyc < free_at) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout at cycle %0d: still busy, expected idle", cyc);
    end
  endtask

  task automatic write_burst(input logic [7:0] a, input logic [255:0] d, input logic [31:0] m);
    wait_idle();
    for (int i = 0; i < Burst; i++) begin
      drive(1'b0, i == 0, 1'b1, a, d[64*i +: 64], m[8*i +: 8]);
    end
  endtask

  task automatic read_burst(input logic [7:0] a);
    wait_idle();
    rd_log.delete();
    drive(1'b0, 1'b1, 1'b0, a, 64'h0, 8'hFF);
    wait_idle();
  endtask

  task automatic check_log(input string name, input logic [255:0] exp);
    check({name, "_count"}, 64'(rd_log.size()), 64'(Burst));
    for (int i = 0; i < Burst; i++) begin
      if (i < rd_log.size()) check(name, rd_log[i], exp[64*i +: 64]);
    end
  endtask

  task automatic check_first(input string name, input logic [63:0] exp);
    if (rd_log.size() > 0) check(name, rd_log[0], exp);
    else check({name, "_count"}, 64'(rd_log.size()), 64'(Burst));
  endtask

  localparam logic [63:0] B1 = 64'h1111111111111111;
  localparam logic [63:0] B2 = 64'h2222222222222222;
  localparam logic [63:0] B3 = 64'h3333333333333333;
  localparam logic [63:0] B4 = 64'h4444444444444444;
  localparam logic [63:0] WA = 64'hAAAAAAAA00000001;
  localparam logic [63:0] WB = 64'hBBBBBBBB00000002;
  localparam logic [63:0] WC = 64'hCCCCCCCC00000003;
  localparam logic [63:0] WD = 64'hDDDDDDDD00000004;
  localparam logic [63:0] E0 = 64'hE0E0E0E0_0BADF00D;
  localparam logic [63:0] E1 = 64'hE1E1E1E1_1BADF00D;
  localparam logic [63:0] E2 = 64'hE2E2E2E2_2BADF00D;
  localparam logic [63:0] E3 = 64'hE3E3E3E3_3BADF00D;

  initial begin
    logic [63:0] beats [4];
    logic [255:0] pat;
    beats[0] = B1; beats[1] = B2; beats[2] = B3; beats[3] = B4;

    // Reset for two cycles, write 0x10 at T = 10, read 0x10 at R = 14.
    tbl[0]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 64'h0, 8'hFF, 1'b0, 1'b0, 64'h0);
    tbl[1]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 64'h0, 8'hFF, 1'b1, 1'b0, 64'h0);
    for (int i = 2; i < 10; i++) begin
      tbl[i] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 8'hFF, 1'b1, 1'b0, 64'h0);
    end
    tbl[10] = mk(1'b1, 1'b0, 1'b1, 1'b1, 8'h10, B1, 8'h00, 1'b0, 1'b0, 64'h0);
    tbl[11] = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h10, B2, 8'h00, 1'b1, 1'b0, 64'h0);
    tbl[12] = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h10, B3, 8'h00, 1'b1, 1'b0, 64'h0);
    tbl[13] = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h10, B4, 8'h00, 1'b1, 1'b0, 64'h0);
    tbl[14] = mk(1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 64'h0, 8'hFF, 1'b0, 1'b0, 64'h0);
    tbl[15] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 8'hFF, 1'b1, 1'b0, 64'h0);
    tbl[16] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 8'hFF, 1'b1, 1'b0, 64'h0);
    for (int i = 0; i < 4; i++) begin
      tbl[17 + i] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 8'hFF, 1'b1, 1'b1, beats[i]);
    end
    tbl[21] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 8'hFF, 1'b0, 1'b0, 64'h0);

    for (int i = 0; i < 22; i++) begin
      if (tbl[i].chk) begin
        check("tbl_busy", 64'(br_busy), 64'(tbl[i].busy));
        check("tbl_valid", 64'(br_rd_data_valid), 64'(tbl[i].valid));
        check("tbl_data", br_rd_data, tbl[i].rd);
      end
      drive(tbl[i].r, tbl[i].en, tbl[i].cmd, tbl[i].addr, tbl[i].wd, tbl[i].mask);
    end

    // Give every address a known value; block 0x10 keeps the first write's contents.
    for (int base = 0; base < 256; base += 4) begin
      if (base == 'h10) pat = {B4, B3, B2, B1};
      else pat = {64'hC0DE000000000000 | 64'(base + 3), 64'hC0DE000000000000 | 64'(base + 2),
                  64'hC0DE000000000000 | 64'(base + 1), 64'hC0DE000000000000 | 64'(base)};
      write_burst(8'(base), pat, 32'h0);
    end

    // Byte mask: only the upper four bytes of beat 0 change.
    write_burst(8'h10, {64'h0, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF}, {8'hFF, 8'hFF, 8'hFF, 8'h0F});
    read_burst(8'h10);
    check_log("mask_rd", {B4, B3, B2, 64'hFFFFFFFF11111111});

    // Address wrap across 0xFF -> 0x00.
    write_burst(8'hFE, {WD, WC, WB, WA}, 32'h0);
    read_burst(8'hFE);
    check_log("wrap_rd", {WD, WC, WB, WA});
    read_burst(8'hFF);
    check_first("wrap_ff", WB);
    read_burst(8'h00);
    check_first("wrap_00", WC);
    read_burst(8'h01);
    check_first("wrap_01", WD);

    // Read strobe during a write burst is dropped; next command at T+4 is honoured.
    wait_idle();
    rd_log.delete();
    drive(1'b0, 1'b1, 1'b1, 8'h30, E0, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'h10, E1, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00, E2, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00, E3, 8'h00);
    check("drop_busy_t4", 64'(br_busy), 64'(0));
    check("drop_no_rd", 64'(rd_log.size()), 64'(0));
    drive(1'b0, 1'b1, 1'b0, 8'h30, 64'h0, 8'hFF);
    wait_idle();
    check_log("drop_rd", {E3, E2, E1, E0});
    read_burst(8'h10);
    check_log("drop_mem", {B4, B3, B2, 64'hFFFFFFFF11111111});

    // Reset asserted at R+4 of a read: only the beats at R+3 and R+4 appear.
    wait_idle();
    rd_log.delete();
    drive(1'b0, 1'b1, 1'b0, 8'h30, 64'h0, 8'hFF);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 8'hFF);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 64'h0, 8'hFF);
    check("rstrd_valid", 64'(br_rd_data_valid), 64'(0));
    check("rstrd_busy", 64'(br_busy), 64'(1));
    wait_idle();
    check("rstrd_beats", 64'(rd_log.size()), 64'(2));
    read_burst(8'h30);
    check_log("rstrd_mem", {E3, E2, E1, E0});

    // Random traffic, including occasional resets, against the model.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, 1'($urandom),
            8'($urandom), {$urandom, $urandom},
            ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00);
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/burst_ram_responder.md
Name: burst_ram_responder

Overview:
- Responder end of the br_ burst-RAM command interface that the SoC/RAMIO cache drives.
- Synthesizable BRAM-backed model of the external burst RAM, used in simulation benches and small-FPGA builds in place of the vendor memory controller.
- Accepts single-cycle read/write burst commands, stores/returns BURST_DATA_COUNT consecutive beats and reports busy, including a post-reset init (calibration) period.

Parameters:
- DEPTH_BITWIDTH, 8, address width; memory holds 2^DEPTH_BITWIDTH beats.
- DATA_BITWIDTH, 64, beat width in bits; must be a multiple of 8.
- BURST_DATA_COUNT, 4, beats per burst, >=1.
- READ_LATENCY, 2, idle cycles between read command acceptance and the first valid beat, >=0.
- INIT_CYCLES, 8, cycles busy stays high after reset release, >=1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- br_cmd  in  1  0 = read, 1 = write
- br_cmd_en  in  1  command strobe, sampled only when br_busy=0
- br_addr  in  DEPTH_BITWIDTH  beat address of the first beat
- br_wr_data  in  DATA_BITWIDTH  write beat data
- br_data_mask  in  DATA_BITWIDTH/8  per-byte mask; 1 = byte not written
- br_rd_data  out  DATA_BITWIDTH  read beat data
- br_rd_data_valid  out  1  br_rd_data holds a read beat
- br_busy  out  1  command not accepted this cycle

Behaviour:
- Clock and reset: clk; reset rst, synchronous, active-high.
- Registered outputs. Reset values: br_busy=1, br_rd_data_valid=0, br_rd_data=0.
- Memory array contents are not cleared by reset.
- States:
  - INIT: counts INIT_CYCLES; br_busy=1. After the cycle in which rst is sampled high, br_busy stays 1 for INIT_CYCLES further cycles, then goes to IDLE.
  - IDLE: br_busy=0. Command accepted at cycle T when br_cmd_en=1 && br_busy=0. br_cmd=1 goes to WRITE, br_cmd=0 goes to READ_WAIT (or READ if READ_LATENCY=0).
  - WRITE: beat i (0..N-1) is taken from br_wr_data/br_data_mask at cycle T+i and written to address (br_addr+i) mod 2^DEPTH_BITWIDTH. Beat 0 is the data present with the command. br_busy=1 on T+1..T+N-1; the next command is accepted at T+N. If N=1, no busy cycle.
  - READ_WAIT: READ_LATENCY cycles with no output.
  - READ: br_rd_data_valid=1 on cycles T+1+READ_LATENCY .. T+READ_LATENCY+N, carrying beats (addr+i) mod depth in order, consecutive with no gaps. br_busy=1 on T+1..T+READ_LATENCY+N; returns to IDLE with br_busy=0 at T+READ_LATENCY+N+1.
- br_rd_data=0 whenever br_rd_data_valid=0.
- Byte masking: byte j of a beat is updated only if br_data_mask[j]=0. A mask of all ones makes the write a no-op that still consumes the burst cycles.
- Address latched at acceptance. br_addr, br_cmd and br_cmd_en are ignored during WRITE, READ_WAIT and READ.
- br_cmd_en while br_busy=1 is dropped silently: no queuing, no error.
- Read-after-write: a read accepted after a write burst completes returns the written data. No overlap is possible, so there is no bypass requirement.
- Address wrap: beat addresses wrap modulo 2^DEPTH_BITWIDTH; there is no burst-alignment requirement.
- Reset mid-operation:
  - The burst is aborted; remaining beats are neither written nor returned.
  - Beats already written remain.
  - br_rd_data_valid=0 and br_busy=1 from the cycle after rst is sampled; INIT restarts.
- Counters sized to hold max(INIT_CYCLES, READ_LATENCY, BURST_DATA_COUNT); no overflow permitted.

Test Plan:
All scenarios use default parameters.
- Reset: rst high 2 cycles, then low -> br_busy=1 for exactly 8 cycles after release, then 0; br_rd_data_valid=0 and br_rd_data=0 throughout.
- Write then read:
  - Stimulus: write at addr 0x10 with beats 0x1111111111111111, 0x2222…, 0x3333…, 0x4444…, mask 0x00, command at T. Then read 0x10, command at R.
  - Response: busy on T+1..T+3. Valid on R+3..R+6 with the four beats in order. busy low again at R+7.
- Byte mask: write 0xFFFFFFFFFFFFFFFF to 0x10 beat 0 with mask 0x0F, over the scenario 2 contents -> read beat 0 = 0xFFFFFFFF11111111; beats 1-3 unchanged.
- Wrap: write at 0xFE with beats A, B, C, D -> single-beat reads of 0xFE, 0xFF, 0x00, 0x01 return A, B, C, D.
- Busy drop: during a write burst, assert br_cmd_en with br_cmd=0 at T+1 -> no read beats appear; memory unchanged by that strobe; the next accepted command at T+4 behaves normally.
- Reset mid-read: read accepted at R, rst asserted at R+4 -> br_rd_data_valid=0 from R+5; busy high for INIT; a later read returns intact memory.
